// File: rtl/neuron_mem_arbiter_pkg.sv
// Shared types and width helper for the neuron SRAM arbiter.
package tinyodin_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  typedef enum logic [1:0] {NONE, CORE, HOST} owner_e;

  function automatic int wait_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/neuron_mem_arbiter_arb_starve_counter.sv
// Saturating host wait counter: counts up to STARVE_MAX, cleared on demand.
module arb_starve_counter
  import tinyodin_arb_pkg::*;
#(
  parameter int STARVE_MAX = 15,
  parameter int WAIT_W     = wait_w(STARVE_MAX)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [WAIT_W-1:0] cnt_o,
  output logic              sat_o
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(STARVE_MAX);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/neuron_mem_arbiter.sv
// Core/host arbiter for the single-port neuron state SRAM with RMW locking.
// Optional ARB_PERF_CNT_EN adds host stall and core grant counters.
module neuron_mem_arbiter
  import tinyodin_arb_pkg::*;
#(
  parameter int M          = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic          core_lock_i,
  input  logic [M-1:0]  core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [M-1:0]  host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_gnt_o,
  output logic          host_rvalid_o,
  output logic [DW-1:0] host_rdata_o,
  output logic          mem_cs_o,
  output logic          mem_we_o,
  output logic [M-1:0]  mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          locked_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   host_stall_cnt_o,
  output logic [31:0]   core_grant_cnt_o
`endif
);

  localparam int WAIT_W = wait_w(STARVE_MAX);

  arb_state_e        state_q, state_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_sat;
  logic              host_win;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX),
    .WAIT_W     (WAIT_W)
  ) u_starve (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (host_req_i && !host_gnt_o),
    .clr_i (host_gnt_o || !host_req_i),
    .cnt_o (wait_cnt),
    .sat_o (wait_sat)
  );

  // The starvation override only acts in IDLE; a held lock always wins.
  always_comb begin
    host_win   = 1'b0;
    core_gnt_o = 1'b0;
    host_gnt_o = 1'b0;
    if (state_q == IDLE) begin
      host_win   = host_req_i && (wait_sat || !core_req_i);
      host_gnt_o = host_win;
      core_gnt_o = core_req_i && !host_win;
    end else begin
      core_gnt_o = core_req_i;
    end
  end

  always_comb begin
    mem_cs_o    = core_gnt_o || host_gnt_o;
    mem_we_o    = host_gnt_o ? host_we_i    : (core_gnt_o && core_we_i);
    mem_addr_o  = host_gnt_o ? host_addr_i  : core_addr_i;
    mem_wdata_o = host_gnt_o ? host_wdata_i : core_wdata_i;
  end

  always_comb begin
    state_d    = state_q;
    rd_owner_d = NONE;
    if (core_gnt_o && !core_we_i) begin
      rd_owner_d = CORE;
    end else if (host_gnt_o && !host_we_i) begin
      rd_owner_d = HOST;
    end
    case (state_q)
      IDLE:    if (core_gnt_o && !core_we_i && core_lock_i) state_d = LOCKED;
      LOCKED:  if (core_gnt_o && core_we_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rd_owner_q <= NONE;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // SRAM data arrives one cycle after the read, aligned with the registered owner.
  assign core_rvalid_o = (rd_owner_q == CORE);
  assign host_rvalid_o = (rd_owner_q == HOST);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
  assign locked_o      = (state_q == LOCKED);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] host_stall_cnt_q, core_grant_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      host_stall_cnt_q <= '0;
      core_grant_cnt_q <= '0;
    end else begin
      if (host_req_i && !host_gnt_o) host_stall_cnt_q <= host_stall_cnt_q + 32'd1;
      if (core_gnt_o)                core_grant_cnt_q <= core_grant_cnt_q + 32'd1;
    end
  end

  assign host_stall_cnt_o = host_stall_cnt_q;
  assign core_grant_cnt_o = core_grant_cnt_q;
`endif

endmodule
